// File: rtl/count_occurrence_monitor.sv
`default_nettype none
// ============================================================================
// count_occurrence_monitor : counts cycles where count == MAX_VALUE in a window
// Revision: 1.0
// ============================================================================
module count_occurrence_monitor #(
    parameter int               WIDTH       = 4,
    parameter logic [WIDTH-1:0] MAX_VALUE   = 4'b1111,
    parameter int               MAX_REPEATS = 5,
    parameter int               WINDOW      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] count,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic [7:0]       hits
);

    localparam logic [7:0]  C_REP_MAX   = 8'(MAX_REPEATS);
    localparam logic [8:0]  C_REP_LIMIT = 9'(MAX_REPEATS + 1);
    localparam logic [15:0] C_WIN_LOAD  = 16'(WINDOW);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OBSERVE = 2'd1,
        ST_VERDICT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] win_q, win_d;
    logic [7:0]  hits_q, hits_d;
    logic        pass_q, pass_d;
    logic        fail_q, fail_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic        is_hit;
    logic [8:0]  hit_cnt;

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        hits_d  = hits_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        done_d  = 1'b0;
        is_hit  = (count == MAX_VALUE);
        // One bit wider than hits so the limit is still detectable at 255
        hit_cnt = {1'b0, hits_q} + 9'd1;

        case (state_q)
            ST_IDLE, ST_VERDICT: begin
                if (start) begin
                    state_d = ST_OBSERVE;
                    win_d   = C_WIN_LOAD;
                    hits_d  = 8'd0;
                    pass_d  = 1'b0;
                    fail_d  = 1'b0;
                end
            end
            ST_OBSERVE: begin
                win_d = win_q - 16'd1;
                if (is_hit) begin
                    hits_d = hit_cnt[8] ? 8'hFF : hit_cnt[7:0];
                end
                if (is_hit && (hit_cnt == C_REP_LIMIT)) begin
                    state_d = ST_VERDICT;
                    win_d   = 16'd0;
                    fail_d  = 1'b1;
                    done_d  = 1'b1;
                end else if (win_q == 16'd1) begin
                    state_d = ST_VERDICT;
                    done_d  = 1'b1;
                    if ((hits_d != 8'd0) && (hits_d <= C_REP_MAX)) begin
                        pass_d = 1'b1;
                    end else begin
                        fail_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_OBSERVE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            win_q   <= 16'd0;
            hits_q  <= 8'd0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            hits_q  <= hits_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign pass = pass_q;
    assign fail = fail_q;
    assign hits = hits_q;

endmodule
`default_nettype wire

// File: doc/count_occurrence_monitor.md
COUNT_OCCURRENCE_MONITOR -- requirements
Module: count_occurrence_monitor

Interface
REQ-001 Parameter WIDTH, default 4, width of the observed count bus.
REQ-002 Parameter MAX_VALUE, default 4'b1111, value counted as a hit.
REQ-003 Parameter MAX_REPEATS, default 5, upper bound on hits per window; legal range 1..255.
REQ-004 Parameter WINDOW, default 32, observation window length in clock cycles; legal range 1..65535.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 count  input  WIDTH  observed counter value, sampled each rising clk edge.
REQ-008 start  input  1  single-cycle request to open a new observation window.
REQ-009 busy  output  1  high while a window is open (state OBSERVE).
REQ-010 done  output  1  one-cycle pulse when a verdict is produced.
REQ-011 pass  output  1  verdict: hits in [1:MAX_REPEATS]; held until next start or reset.
REQ-012 fail  output  1  verdict: zero hits or more than MAX_REPEATS hits; held until next start or reset.
REQ-013 hits  output  8  number of hit cycles in the current or last window, saturating at 255.

Function
REQ-014 States SHALL be IDLE, OBSERVE and VERDICT.
REQ-015 A hit SHALL be any sampled cycle in OBSERVE with count == MAX_VALUE; hits need not be consecutive, and each matching cycle counts once.
REQ-016 start sampled high in IDLE or VERDICT SHALL, at that edge, clear hits, pass and fail, load the window counter with WINDOW, and enter OBSERVE.
REQ-017 start while in OBSERVE SHALL be ignored.
REQ-018 The window SHALL cover the WINDOW sampling edges following the start edge; the start-edge count value is not sampled.
REQ-019 In OBSERVE, each edge SHALL decrement the window counter and increment hits on a hit.
REQ-020 If a hit makes hits equal MAX_REPEATS+1, the block SHALL enter VERDICT at that edge with fail=1 (early fail); remaining window cycles are not observed.
REQ-021 On the last window edge (counter reaching 0), the block SHALL include that edge's hit, enter VERDICT, and set pass=1 if 1 <= hits <= MAX_REPEATS, else fail=1.
REQ-022 If the last window edge is also the (MAX_REPEATS+1)th hit, the verdict SHALL be fail.
REQ-023 done SHALL be high for exactly the one cycle following entry to VERDICT; pass and fail SHALL never both be high.
REQ-024 Verdict latency SHALL be WINDOW cycles from start edge to done for a full window, or fewer on early fail.
REQ-025 VERDICT SHALL hold pass, fail and hits stable until start or reset; start in VERDICT behaves per REQ-016 and suppresses nothing already reported.
REQ-026 hits SHALL saturate at 255 and never wrap.
REQ-027 busy SHALL equal (state == OBSERVE), registered, with no combinational path from count or start.

Reset
REQ-028 reset low SHALL asynchronously force state IDLE, busy=0, done=0, pass=0, fail=0, hits=0 and window counter 0, regardless of state.
REQ-029 Deassertion of reset mid-window SHALL leave the block in IDLE, with no verdict produced for the aborted window.

Verification
(WINDOW=16, MAX_REPEATS=5, MAX_VALUE=15 for all scenarios)
REQ-030 start pulse; count=15 on window cycles 3, 9, 12 -> done 16 cycles after start, pass=1, fail=0, hits=3.
REQ-031 start pulse; count never 15 -> done at cycle 16, fail=1, hits=0.
REQ-032 start pulse; count=15 on cycles 1..6 -> done one cycle after the cycle-6 edge, fail=1, hits=6, busy drops immediately.
REQ-033 start pulse; 5 hits by cycle 10 plus a hit on cycle 16 -> fail=1, hits=6; variant with exactly 5 hits including cycle 16 -> pass=1, hits=5.
REQ-034 Second start pulse at cycle 8 of an open window -> ignored, done still at cycle 16; start in VERDICT -> pass/fail cleared, new window opens.
REQ-035 Assert reset at cycle 7 of a window with 2 hits -> all outputs 0 immediately; release, no done pulse until a new start.
